// File: rtl/code_entry.sv
// Switch-code front end for the ATM controller: debounces raw code values into
// digit events, assembles NDIG digits into a code word and aborts stale entries.
module code_entry #(
  parameter int NDIG        = 3,
  parameter int STABLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                cartao,
  input  logic [2:0]          cod,
  output logic                dig_valid,
  output logic [2:0]          dig,
  output logic [1:0]          dig_idx,
  output logic                code_ready,
  output logic [3*NDIG-1:0]   code_out,
  output logic                timeout,
  output logic                busy
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ZERO, WAIT_DIGIT} state_t;

  state_t              state;
  logic [SW-1:0]       stab_cnt;
  logic [2:0]          prev_cod;
  logic [TW-1:0]       tcnt;
  logic [3*NDIG-1:0]   shift_reg;

  logic [SW-1:0]       stab_next;
  logic [TW-1:0]       tcnt_inc;
  logic [3*NDIG-1:0]   shift_next;
  logic                accept;
  logic                last_digit;
  logic                tmo_hit;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v == SW'(STABLE_CYC)) return v;
    return v + SW'(1);
  endfunction

  // Stability tracking: a run restarts whenever the nonzero value changes.
  always_comb begin
    stab_next = '0;
    if (cod != 3'd0)
      stab_next = (stab_cnt != '0 && cod == prev_cod) ? sat_inc(stab_cnt) : SW'(1);
  end

  assign accept     = (state == WAIT_DIGIT) && (stab_next == SW'(STABLE_CYC));
  assign last_digit = (dig_idx == 2'(NDIG - 1));
  assign tcnt_inc   = tcnt + TW'(1);
  assign tmo_hit    = (TIMEOUT_CYC != 0) && (dig_idx != 2'd0) && (tcnt_inc == TW'(TIMEOUT_CYC));
  assign shift_next = (shift_reg << 3) | (3*NDIG)'(cod);
  assign busy       = cartao && (dig_idx != 2'd0);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stab_cnt   <= '0;
      prev_cod   <= '0;
      tcnt       <= '0;
      shift_reg  <= '0;
      dig_valid  <= 1'b0;
      dig        <= '0;
      dig_idx    <= '0;
      code_ready <= 1'b0;
      code_out   <= '0;
      timeout    <= 1'b0;
    end else begin
      dig_valid  <= 1'b0;
      code_ready <= 1'b0;
      timeout    <= 1'b0;
      prev_cod   <= cod;
      // Card removal outranks accept and timeout; no pulses on abort.
      if (!cartao) begin
        state     <= IDLE;
        stab_cnt  <= '0;
        tcnt      <= '0;
        shift_reg <= '0;
        dig_idx   <= '0;
      end else if (accept) begin
        dig       <= cod;
        dig_valid <= 1'b1;
        stab_cnt  <= '0;
        tcnt      <= '0;
        state     <= WAIT_ZERO;
        if (last_digit) begin
          code_out   <= shift_next;
          code_ready <= 1'b1;
          shift_reg  <= '0;
          dig_idx    <= '0;
        end else begin
          shift_reg <= shift_next;
          dig_idx   <= dig_idx + 2'd1;
        end
      end else if (tmo_hit) begin
        timeout   <= 1'b1;
        stab_cnt  <= '0;
        tcnt      <= '0;
        shift_reg <= '0;
        dig_idx   <= '0;
        state     <= WAIT_ZERO;
      end else begin
        if (dig_idx != 2'd0 && TIMEOUT_CYC != 0) tcnt <= tcnt_inc;
        case (state)
          IDLE:       state <= WAIT_ZERO;
          WAIT_ZERO:  if (cod == 3'd0) state <= WAIT_DIGIT;
          WAIT_DIGIT: stab_cnt <= stab_next;
          default:    state <= IDLE;
        endcase
      end
    end
  end

endmodule
